// File: rtl/rbus_lane_sequencer.sv
// Initiator-side sequencer for the reconfigurable bus: configuration handshake plus
// circular lane strobes. Optional stall counter is built when RBUSSEQ_STALL_CNT_EN is defined.
module rbus_lane_sequencer #(
  parameter int NUM_LANES       = 13,
  parameter int BITWIDTH_W_ROWS = 4,
  parameter int BITWIDTH_IMG    = 8
) (
  input  logic                       RBUSSEQ_Clk,
  input  logic                       RBUSSEQ_Reset,
  input  logic                       RBUSSEQ_Start,
  input  logic [BITWIDTH_W_ROWS-1:0] RBUSSEQ_W_Rows,
  input  logic [BITWIDTH_IMG-1:0]    RBUSSEQ_Img_Cols,
  input  logic [BITWIDTH_IMG-1:0]    RBUSSEQ_Img_Rows,
  input  logic                       RBUSSEQ_Pix_Valid,
  input  logic                       RBUSSEQ_Conf_Already,
  output logic                       RBUSSEQ_Set_Conf,
  output logic                       RBUSSEQ_Set_Conf_Already_Ok,
  output logic                       RBUSSEQ_Pix_Ready,
  output logic [NUM_LANES-1:0]       RBUSSEQ_SetEn,
  output logic [NUM_LANES-1:0]       RBUSSEQ_OEn,
  output logic [NUM_LANES-1:0]       RBUSSEQ_Wptclr,
  output logic [NUM_LANES-1:0]       RBUSSEQ_Rptclr,
  output logic                       RBUSSEQ_Win_Valid,
  output logic                       RBUSSEQ_Busy,
`ifdef RBUSSEQ_STALL_CNT_EN
  output logic [15:0]                RBUSSEQ_Stall_Count,
`endif
  output logic                       RBUSSEQ_Done
);

  localparam logic [BITWIDTH_W_ROWS-1:0] WR_ZERO  = {BITWIDTH_W_ROWS{1'b0}};
  localparam logic [BITWIDTH_W_ROWS-1:0] WR_ONE   = BITWIDTH_W_ROWS'(1);
  localparam logic [BITWIDTH_W_ROWS-1:0] WR_MAX   = BITWIDTH_W_ROWS'(NUM_LANES);
  localparam logic [BITWIDTH_IMG-1:0]    IMG_ZERO = {BITWIDTH_IMG{1'b0}};
  localparam logic [BITWIDTH_IMG-1:0]    IMG_ONE  = BITWIDTH_IMG'(1);
  localparam logic [NUM_LANES-1:0]       LANES_0  = {NUM_LANES{1'b0}};
  localparam logic [NUM_LANES-1:0]       LANES_1  = {NUM_LANES{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CONF_REQ   = 3'd1,
    S_CONF_ACK   = 3'd2,
    S_ROW_CLR    = 3'd3,
    S_ROW_STREAM = 3'd4,
    S_ROW_END    = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [BITWIDTH_W_ROWS-1:0] lane);
    lane_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << lane;
  endfunction

  // Lanes 0..wr-1 set; for wr == NUM_LANES the shift empties the vector so all lanes are set.
  function automatic logic [NUM_LANES-1:0] lanes_below(input logic [BITWIDTH_W_ROWS-1:0] wr);
    lanes_below = ~(LANES_1 << wr);
  endfunction

  function automatic logic [BITWIDTH_W_ROWS-1:0] clamp_wr(input logic [BITWIDTH_W_ROWS-1:0] w);
    if (w == WR_ZERO) begin
      clamp_wr = WR_ONE;
    end else if (w > WR_MAX) begin
      clamp_wr = WR_MAX;
    end else begin
      clamp_wr = w;
    end
  endfunction

  function automatic logic [BITWIDTH_IMG-1:0] clamp_img(input logic [BITWIDTH_IMG-1:0] n);
    clamp_img = (n == IMG_ZERO) ? IMG_ONE : n;
  endfunction

  state_t                     state_q, state_d;
  logic [BITWIDTH_W_ROWS-1:0] wr_q, wr_d;
  logic [BITWIDTH_IMG-1:0]    cols_q, cols_d;
  logic [BITWIDTH_IMG-1:0]    rows_q, rows_d;
  logic [BITWIDTH_IMG-1:0]    col_cnt_q, col_cnt_d;
  logic [BITWIDTH_IMG-1:0]    row_cnt_q, row_cnt_d;
  logic [BITWIDTH_W_ROWS-1:0] wlane_q, wlane_d;
  logic [BITWIDTH_W_ROWS-1:0] filled_q, filled_d;

  logic                 set_conf_q, set_conf_d;
  logic                 conf_ok_q, conf_ok_d;
  logic                 pix_ready_q, pix_ready_d;
  logic [NUM_LANES-1:0] set_en_q, set_en_d;
  logic [NUM_LANES-1:0] oen_q, oen_d;
  logic [NUM_LANES-1:0] wptclr_q, wptclr_d;
  logic [NUM_LANES-1:0] rptclr_q, rptclr_d;
  logic                 win_valid_q, win_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic accept_s;
  logic read_now_s;
  logic read_next_s;

  assign accept_s = (state_q == S_ROW_STREAM) && RBUSSEQ_Pix_Valid;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    cols_d    = cols_q;
    rows_d    = rows_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    wlane_d   = wlane_q;
    filled_d  = filled_q;

    case (state_q)
      S_IDLE: begin
        if (RBUSSEQ_Start) begin
          state_d   = S_CONF_REQ;
          wr_d      = clamp_wr(RBUSSEQ_W_Rows);
          cols_d    = clamp_img(RBUSSEQ_Img_Cols);
          rows_d    = clamp_img(RBUSSEQ_Img_Rows);
          col_cnt_d = IMG_ZERO;
          row_cnt_d = IMG_ZERO;
          wlane_d   = WR_ZERO;
          filled_d  = WR_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONF_REQ: begin
        if (RBUSSEQ_Conf_Already) begin
          state_d = S_CONF_ACK;
        end else begin
          state_d = S_CONF_REQ;
        end
      end
      S_CONF_ACK: state_d = S_ROW_CLR;
      S_ROW_CLR:  state_d = S_ROW_STREAM;
      S_ROW_STREAM: begin
        if (accept_s && (col_cnt_q == cols_q - IMG_ONE)) begin
          col_cnt_d = IMG_ZERO;
          state_d   = S_ROW_END;
        end else if (accept_s) begin
          col_cnt_d = col_cnt_q + IMG_ONE;
        end else begin
          col_cnt_d = col_cnt_q;
        end
      end
      S_ROW_END: begin
        wlane_d   = (wlane_q == wr_q - WR_ONE) ? WR_ZERO : wlane_q + WR_ONE;
        filled_d  = (filled_q < wr_q - WR_ONE) ? filled_q + WR_ONE : filled_q;
        row_cnt_d = row_cnt_q + IMG_ONE;
        if (row_cnt_q == rows_q - IMG_ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ROW_CLR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A window exists once WR-1 rows precede the one being written.
    read_now_s  = (filled_q >= wr_q - WR_ONE);
    read_next_s = (filled_d >= wr_d - WR_ONE);

    set_conf_d  = (state_d == S_CONF_REQ);
    conf_ok_d   = (state_d == S_CONF_ACK);
    pix_ready_d = (state_d == S_ROW_STREAM);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    wptclr_d    = (state_d == S_ROW_CLR) ? lane_onehot(wlane_d) : LANES_0;
    rptclr_d    = ((state_d == S_ROW_CLR) && read_next_s) ? lanes_below(wr_d) : LANES_0;
    set_en_d    = accept_s ? lane_onehot(wlane_q) : LANES_0;
    oen_d       = (accept_s && read_now_s) ? lanes_below(wr_q) : LANES_0;
    win_valid_d = accept_s && read_now_s;
  end

  // State, configuration, counters and output registers
  always_ff @(posedge RBUSSEQ_Clk) begin
    if (RBUSSEQ_Reset) begin
      state_q     <= S_IDLE;
      wr_q        <= WR_ZERO;
      cols_q      <= IMG_ZERO;
      rows_q      <= IMG_ZERO;
      col_cnt_q   <= IMG_ZERO;
      row_cnt_q   <= IMG_ZERO;
      wlane_q     <= WR_ZERO;
      filled_q    <= WR_ZERO;
      set_conf_q  <= 1'b0;
      conf_ok_q   <= 1'b0;
      pix_ready_q <= 1'b0;
      set_en_q    <= LANES_0;
      oen_q       <= LANES_0;
      wptclr_q    <= LANES_0;
      rptclr_q    <= LANES_0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      wlane_q     <= wlane_d;
      filled_q    <= filled_d;
      set_conf_q  <= set_conf_d;
      conf_ok_q   <= conf_ok_d;
      pix_ready_q <= pix_ready_d;
      set_en_q    <= set_en_d;
      oen_q       <= oen_d;
      wptclr_q    <= wptclr_d;
      rptclr_q    <= rptclr_d;
      win_valid_q <= win_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef RBUSSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Upstream starvation counter: ROW_STREAM cycles without a valid pixel
  always_comb begin
    if ((state_q == S_IDLE) && RBUSSEQ_Start) begin
      stall_cnt_d = 16'd0;
    end else if ((state_q == S_ROW_STREAM) && !RBUSSEQ_Pix_Valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge RBUSSEQ_Clk) begin
    if (RBUSSEQ_Reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign RBUSSEQ_Stall_Count = stall_cnt_q;
`else
  // Stall counter not built.
`endif

  assign RBUSSEQ_Set_Conf            = set_conf_q;
  assign RBUSSEQ_Set_Conf_Already_Ok = conf_ok_q;
  assign RBUSSEQ_Pix_Ready           = pix_ready_q;
  assign RBUSSEQ_SetEn               = set_en_q;
  assign RBUSSEQ_OEn                 = oen_q;
  assign RBUSSEQ_Wptclr              = wptclr_q;
  assign RBUSSEQ_Rptclr              = rptclr_q;
  assign RBUSSEQ_Win_Valid           = win_valid_q;
  assign RBUSSEQ_Busy                = busy_q;
  assign RBUSSEQ_Done                = done_q;

endmodule

// File: doc/rbus_lane_sequencer.md
Name: rbus_lane_sequencer

Overview:
- Initiator side of the reconfigurable bus. It runs the configuration handshake with the bus, then generates the 13 lane strobe groups (SetEn, OEn, Wptclr, Rptclr) that the bus fans out to the line-buffer cells.
- It streams an image row by row. Write rows rotate circularly over the active lanes (one lane per kernel row). Once a full kernel-height window is buffered, it raises all active read strobes.

Parameters:
- NUM_LANES, 13, number of lane strobe groups; fixed to match the bus.
- BITWIDTH_W_ROWS, 4, width of the kernel-rows input.
- BITWIDTH_IMG, 8, width of the image column and row count inputs.

Ports:
- RBUSSEQ_Clk  in  1  single clock; all logic on posedge.
- RBUSSEQ_Reset  in  1  synchronous, active-high reset.
- RBUSSEQ_Start  in  1  one-cycle start pulse; ignored unless in IDLE.
- RBUSSEQ_W_Rows  in  BITWIDTH_W_ROWS  kernel rows, legal 1..13; latched at Start.
- RBUSSEQ_Img_Cols  in  BITWIDTH_IMG  pixels per row, legal 1..255; latched at Start.
- RBUSSEQ_Img_Rows  in  BITWIDTH_IMG  rows per image, legal 1..255; latched at Start.
- RBUSSEQ_Pix_Valid  in  1  upstream pixel valid.
- RBUSSEQ_Conf_Already  in  1  bus reports its configuration is complete.
- RBUSSEQ_Set_Conf  out  1  configuration request to the bus.
- RBUSSEQ_Set_Conf_Already_Ok  out  1  one-cycle acknowledge of Conf_Already.
- RBUSSEQ_Pix_Ready  out  1  pixel accepted when Valid & Ready.
- RBUSSEQ_SetEn  out  NUM_LANES  lane write strobes; bit k drives bus lane k.
- RBUSSEQ_OEn  out  NUM_LANES  lane read strobes.
- RBUSSEQ_Wptclr  out  NUM_LANES  lane write-pointer clear.
- RBUSSEQ_Rptclr  out  NUM_LANES  lane read-pointer clear.
- RBUSSEQ_Win_Valid  out  1  a window column is being read this cycle.
- RBUSSEQ_Busy  out  1  high in every state except IDLE.
- RBUSSEQ_Done  out  1  one-cycle pulse at end of image.

Behaviour:
- Reset:
  - State goes to IDLE; all counters are cleared.
  - All outputs read 0 in the cycle after reset is sampled, and remain 0 until the next Start.
  - Reset overrides everything, including mid-stream and mid-handshake.
- Input clamping at latch time:
  - W_Rows = 0 is treated as 1; W_Rows > 13 is treated as 13. The result is WR.
  - Img_Cols = 0 or Img_Rows = 0 is treated as 1.
- FSM states: IDLE, CONF_REQ, CONF_ACK, ROW_CLR, ROW_STREAM, ROW_END, DONE.
  - IDLE: Start moves to CONF_REQ and latches the configuration.
  - CONF_REQ: Set_Conf is held high until Conf_Already = 1, then the FSM moves to CONF_ACK.
  - CONF_ACK: Set_Conf_Already_Ok = 1 for exactly one cycle, then ROW_CLR.
  - ROW_CLR: one cycle.
    - Wptclr[wlane] = 1.
    - If rows_filled ≥ WR-1, Rptclr[k] = 1 for every k < WR.
    - Next state is ROW_STREAM.
  - ROW_STREAM:
    - Pix_Ready = 1.
    - Each accepted pixel produces SetEn[wlane] = 1 in the following cycle (strobes are registered; one-cycle latency).
    - If rows_filled ≥ WR-1, that same cycle also has OEn[k] = 1 for all k < WR, and Win_Valid = 1.
    - On the Img_Cols-th accept, the FSM moves to ROW_END; Pix_Ready drops in the cycle after that accept.
  - ROW_END: one cycle.
    - wlane = (wlane == WR-1) ? 0 : wlane + 1.
    - rows_filled saturates at WR-1.
    - row_cnt increments.
    - If row_cnt was Img_Rows-1, go to DONE; otherwise go to ROW_CLR.
  - DONE: Done = 1 for one cycle, then IDLE.
- Pix_Ready is 0 in every state other than ROW_STREAM, giving 2 bubble cycles per row (ROW_END, ROW_CLR).
- Lanes k ≥ WR never assert any strobe.
- At most one SetEn bit is high in any cycle.
- If Img_Rows < WR, no window is ever read: OEn, Rptclr and Win_Valid stay 0, but Done still pulses.
- Start during Busy is ignored; Conf_Already outside CONF_REQ is ignored.

Optional Feature:
- Macro: RBUSSEQ_STALL_CNT_EN.
- Defined:
  - Adds output port RBUSSEQ_Stall_Count (16 bits).
  - The counter increments on each ROW_STREAM cycle with Pix_Valid = 0, saturating at 0xFFFF.
  - It clears on Start and on reset, and holds its value after DONE.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Config handshake: Start with WR=3; hold Conf_Already low for 5 cycles -> Set_Conf high for those 5 cycles; Ok pulses exactly 1 cycle after Conf_Already rises; Wptclr = 13'b1 one cycle later.
- Rotation: WR=3, Img_Cols=4, Img_Rows=5, Pix_Valid constant 1 -> SetEn lane sequence per row is 0,1,2,0,1, each lane 4 pulses per row. OEn = 13'b111 and Win_Valid on rows 3..5 only (12 pulses total). Rptclr = 13'b111 before rows 3, 4 and 5. Done on the final cycle.
- Backpressure: WR=1, Img_Cols=3, Pix_Valid toggling 1,0,1,0,1 -> exactly 3 SetEn[0] pulses, each 1 cycle after an accept; Win_Valid is coincident with SetEn. With RBUSSEQ_STALL_CNT_EN, Stall_Count = 2.
- Clamp/short image: W_Rows=15, Img_Rows=4, Img_Cols=2 -> WR=13; lanes 0..3 written; OEn, Rptclr and Win_Valid never asserted; Done pulses.
- Reset mid-stream: assert Reset during row 2 of the rotation test -> next cycle all strobes, Busy and Pix_Ready are 0. A fresh Start then begins again from CONF_REQ with wlane=0.
- Start while busy: pulse Start during ROW_STREAM with different W_Rows -> ignored; the original WR is kept.
